// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ula between two requesters.
// Ports: clk/rst_n; req0_*/req1_* request handshakes; rsp0_*/rsp1_* response
// handshakes; rsp_data shared result; ula_a/ula_b/ula_op/ula_out to the ula;
// busy/grant status.
module ula_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic             ula_op,
  input  logic [WIDTH-1:0] ula_out,
  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic any_req;
  logic pick;
  logic rsp_hs;

  // On a tie the port that did not win last time goes first;
  // otherwise whichever port is asking.
  assign any_req = req0_valid | req1_valid;
  assign pick    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign rsp_hs  = grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    data_d     = data_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~pick;
          req1_ready = pick;
          grant_d    = pick;
          a_d        = pick ? req1_a  : req0_a;
          b_d        = pick ? req1_b  : req0_b;
          op_d       = pick ? req1_op : req0_op;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        data_d  = ula_out;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (rsp_hs) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign ula_a    = a_q;
  assign ula_b    = b_q;
  assign ula_op   = op_q;
  assign rsp_data = data_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter with a behavioural ula stub.
// Table-driven operations plus backpressure, reset and round-robin sequences.
module tb_ula_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_op;
  logic [15:0] req0_a, req0_b;
  logic        rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp1_valid, rsp1_ready;
  logic [15:0] rsp_data, ula_a, ula_b, ula_out;
  logic        ula_op, busy, grant;

  int n_cmp;
  int n_err;

  ula_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_data  (rsp_data),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_op    (ula_op),
    .ula_out   (ula_out),
    .busy      (busy),
    .grant     (grant)
  );

  assign ula_out = ula_op ? (ula_a + ula_b) : (ula_a & ula_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        op0;
    logic        v1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        op1;
    logic        g;
    logic [15:0] d;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [15:0] model(logic [15:0] a, logic [15:0] b,
                                        logic op);
    return op ? 16'(a + b) : (a & b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(!v.g));
    chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(v.g));
    chk($sformatf("v%0d busy0", i), 32'(busy), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk($sformatf("v%0d busy1", i), 32'(busy), 32'd1);
    chk($sformatf("v%0d grant", i), 32'(grant), 32'(v.g));
    chk($sformatf("v%0d ula_a", i), 32'(ula_a), 32'(v.g ? v.a1 : v.a0));
    @(negedge clk);
    chk($sformatf("v%0d rsp0_valid", i), 32'(rsp0_valid), 32'(!v.g));
    chk($sformatf("v%0d rsp1_valid", i), 32'(rsp1_valid), 32'(v.g));
    chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(v.d));
    @(negedge clk);
    chk($sformatf("v%0d idle", i), 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    vecs[0] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0,
                1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'hFFFF};
    vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0,
                1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b1, 16'h0100};
    vecs[2] = '{1'b1, 16'h0001, 16'h0003, 1'b1,
                1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0004};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 1'b1,
                1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0,
                1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 16'hF0F0, 16'h0FF0, 1'b0,
                1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h00F0};
    vecs[6] = '{1'b1, 16'hF0F0, 16'h0FF0, 1'b0,
                1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1, 16'h0002};
    vecs[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0,
                1'b1, 16'h1200, 16'h0034, 1'b0, 1'b1, 16'h0000};

    @(negedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst rsp_data", 32'(rsp_data), 32'd0);
    chk("rst ula_a", 32'(ula_a), 32'd0);
    chk("rst rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle ready", 32'({req1_ready, req0_ready}), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Backpressure on port 1 while port 0 waits
    req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h0001; req1_op = 1'b1;
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    #1;
    chk("bp req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0006; req0_b = 16'h0003; req0_op = 1'b0;
    #1;
    chk("bp exec req0_ready", 32'(req0_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp1_valid", c), 32'(rsp1_valid), 32'd1);
      chk($sformatf("bp%0d rsp0_valid", c), 32'(rsp0_valid), 32'd0);
      chk($sformatf("bp%0d rsp_data", c), 32'(rsp_data), 32'h1235);
      chk($sformatf("bp%0d req0_ready", c), 32'(req0_ready), 32'd0);
    end
    @(negedge clk);
    rsp1_ready = 1'b1;
    #1;
    chk("bp done rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("bp done req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    chk("bp idle busy", 32'(busy), 32'd0);
    chk("bp idle req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("bp p0 grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("bp p0 rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("bp p0 rsp_data", 32'(rsp_data), 32'h0002);
    @(negedge clk);

    // Asynchronous reset while a result is waiting
    req1_valid = 1'b1; req1_a = 16'h00AA; req1_b = 16'h0011; req1_op = 1'b1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("ar pre rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("ar pre rsp_data", 32'(rsp_data), 32'h00BB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar busy", 32'(busy), 32'd0);
    chk("ar rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk("ar rsp_data", 32'(rsp_data), 32'd0);
    chk("ar ula", 32'({ula_op, ula_a, ula_b}), 32'd0);
    chk("ar grant", 32'(grant), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Round-robin with both ports continuously valid
    req0_valid = 1'b1; req0_a = 16'h0F0F; req0_b = 16'h00FF; req0_op = 1'b1;
    req1_valid = 1'b1; req1_a = 16'hAAAA; req1_b = 16'h0FF0; req1_op = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic g;
      logic [15:0] d;
      g = 1'(i % 2);
      d = g ? model(req1_a, req1_b, req1_op) : model(req0_a, req0_b, req0_op);
      #1;
      chk($sformatf("rr%0d ready", i), 32'({req1_ready, req0_ready}),
          32'(g ? 2'b10 : 2'b01));
      @(negedge clk);
      chk($sformatf("rr%0d grant", i), 32'(grant), 32'(g));
      @(negedge clk);
      chk($sformatf("rr%0d rsp_valid", i), 32'({rsp1_valid, rsp0_valid}),
          32'(g ? 2'b10 : 2'b01));
      chk($sformatf("rr%0d rsp_data", i), 32'(rsp_data), 32'(d));
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares one combinational ula instance between two requesters (port 0, port 1).
- Round-robin arbitration, valid/ready request handshake, registered operands and result, valid/ready response handshake.
- Sits between the instruction sequencers and the ula.
- Drives ula in_a/in_b/op_select from internal registers and captures ula out one cycle later.

Parameters:
- WIDTH, 16, operand/result width; must match ula.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  port 0 request present.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_a  input  WIDTH  port 0 operand A.
- req0_b  input  WIDTH  port 0 operand B.
- req0_op  input  1  port 0 op_select.
- rsp0_valid  output  1  port 0 result available.
- rsp0_ready  input  1  port 0 consumes result.
- req1_valid / req1_ready / req1_a / req1_b / req1_op / rsp1_valid / rsp1_ready  same as port 0, for port 1.
- rsp_data  output  WIDTH  result register, shared by both ports; qualified by rspN_valid.
- ula_a  output  WIDTH  to ula in_a.
- ula_b  output  WIDTH  to ula in_b.
- ula_op  output  1  to ula op_select.
- ula_out  input  WIDTH  from ula out.
- busy  output  1  high in any state other than IDLE.
- grant  output  1  index of the owning port; valid while busy.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values (on async rst_n low):
  - state = IDLE, last_grant = 1 (port 0 wins first tie).
  - ula_a = 0, ula_b = 0, ula_op = 0, rsp_data = 0, grant = 0.
  - All ready/valid outputs = 0, busy = 0.
- IDLE:
  - reqN_ready is combinational and asserts only in IDLE, for the chosen port only.
  - Choice: if only one reqN_valid is high, pick that port. If both are high, pick the port != last_grant.
  - On a handshake (valid & ready): latch the chosen a/b/op into ula_a/ula_b/ula_op, set grant, go to EXEC.
  - With no valid, stay in IDLE; ula_* registers hold their old values.
- EXEC (exactly 1 cycle):
  - The ula settles on the registered operands.
  - At the clock edge: rsp_data <= ula_out, go to RESP.
- RESP:
  - rsp[grant]_valid = 1; the other rsp valid = 0.
  - rsp_data is held stable.
  - Both reqN_ready = 0; new requests wait, and requesters must hold valid and operands stable.
  - On rsp[grant]_ready = 1: last_grant <= grant, go to IDLE.
  - With rsp_ready low, stay in RESP indefinitely (backpressure).
- Latency and throughput:
  - Request accepted at edge N; rsp_valid is high from cycle N+2 onward.
  - Minimum 3 cycles per operation, with no overlap.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…; no port is starved beyond one other operation.
- rsp_ready on the non-granted port is ignored.
- Width: data is passed through unmodified; the arbiter does no arithmetic; overflow is the ula's concern.
- Simultaneous events: a request arriving in the same cycle as the rsp_ready handshake in RESP is not accepted until the next IDLE cycle.
- Reset mid-operation (EXEC or RESP):
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight result is discarded; requesters reissue.

Test Plan:
- Bench stub for ula: ula_out = op ? a+b : a&b (mod 2^16).
- Single request: port 0 {a=0x0001, b=0x0003, op=1}, rsp0_ready=1 → req0_ready pulse in cycle 0; rsp0_valid at cycle 2; rsp_data=0x0004; busy high for cycles 1–2; back to IDLE at cycle 3.
- Tie after reset: both ports valid; port 0 {0xFFFF, 0xFFFF, op=0}, port 1 {0x00FF, 0x0001, op=1} → port 0 first (rsp_data=0xFFFF), then port 1 (rsp_data=0x0100, grant=1).
- Round-robin: both ports held valid for 4 operations → grant sequence 0,1,0,1; each rsp_valid only on the granted port.
- Backpressure: port 1 request {0x1234, 0x0001, op=1}, rsp1_ready low 5 cycles → rsp1_valid and rsp_data=0x1235 stable throughout; req0_ready stays 0 while port 0 is valid; completion on the cycle rsp1_ready rises.
- Overflow pass-through: port 0 {0xFFFF, 0x0001, op=1} → rsp_data=0x0000.
- Async reset during RESP: assert rst_n low mid-cycle → busy, rsp*_valid, rsp_data and ula_* go to 0 immediately; after release, port 0 wins a tie.
